// File: rtl/i2s_pkg.sv
// Constants and helpers shared by the I2S transmitter and receiver.
package i2s_pkg;

    // Word-select levels: low while the left channel is on the wire.
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    // Width of a counter that runs 0..n-1. Never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divides clk down to SCK and flags the clk cycle
// just before each SCK edge so the rest of the logic can act on it.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_en,
    output logic sck,
    output logic sck_fall,
    output logic sck_rise
);

    localparam int              DW      = cnt_width(CLK_DIV);
    localparam logic [DW-1:0]   DIV_MAX = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;

    // A tick is the cycle whose clock edge toggles SCK.
    assign tick     = tx_en && (div_cnt == DIV_MAX);
    assign sck_fall = tick && sck;
    assign sck_rise = tick && !sck;

    // Half-period counter and SCK register; parked low while disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!tx_en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/transmitter_i2s.sv
// I2S master transmitter. It generates SCK/WS and shifts one stereo frame
// out MSB-first with the one-SCK data delay of Philips timing. A single
// frame holding buffer sits between the valid/ready producer and the
// frame-rate shift register.
module transmitter_i2s
    import i2s_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int SLOT_SIZE = 16,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic                 s_valid,
    input  logic [DATA_SIZE-1:0] s_left,
    input  logic [DATA_SIZE-1:0] s_right,
    output logic                 s_ready,
    output logic                 i2s_sck,
    output logic                 i2s_ws,
    output logic                 i2s_sd,
    output logic                 underrun
);

    localparam int            BW       = cnt_width(SLOT_SIZE);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_SIZE - 1);
    localparam int            FW       = 2 * SLOT_SIZE;

    logic                 sck_fall;
    logic                 sck_rise_unused;  // only a receiver samples on the rising edge
    logic [BW-1:0]        bit_cnt;
    logic [FW-1:0]        sr;
    logic                 buf_full;
    logic [DATA_SIZE-1:0] buf_l;
    logic [DATA_SIZE-1:0] buf_r;
    logic                 accept;
    logic                 slot_end;
    logic                 frame_start;
    logic [SLOT_SIZE-1:0] slot_l;
    logic [SLOT_SIZE-1:0] slot_r;

    i2s_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .tx_en    (tx_en),
        .sck      (i2s_sck),
        .sck_fall (sck_fall),
        .sck_rise (sck_rise_unused)
    );

    assign s_ready     = !buf_full;
    assign accept      = s_valid && !buf_full;
    assign slot_end    = sck_fall && (bit_cnt == BIT_LAST);
    // A frame begins when the last right-slot bit is done and WS goes left.
    assign frame_start = slot_end && (i2s_ws == WS_RIGHT);

    // Samples sit left-justified in their slots; trailing slot bits are zero.
    assign slot_l = SLOT_SIZE'(buf_l) << (SLOT_SIZE - DATA_SIZE);
    assign slot_r = SLOT_SIZE'(buf_r) << (SLOT_SIZE - DATA_SIZE);

    // Holding buffer: fill on handshake, drain into the shift register at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= 1'b0;
            buf_l    <= '0;
            buf_r    <= '0;
        end else if (frame_start && buf_full) begin
            buf_full <= 1'b0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_l    <= s_left;
            buf_r    <= s_right;
        end
    end

    // Slot position and word select, advanced on every SCK falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= BIT_LAST;
            i2s_ws  <= WS_RIGHT;
        end else if (!tx_en) begin
            bit_cnt <= BIT_LAST;
            i2s_ws  <= WS_RIGHT;
        end else if (slot_end) begin
            bit_cnt <= '0;
            i2s_ws  <= ~i2s_ws;
        end else if (sck_fall) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Serialiser: SD always takes the bit shifted out, so the frame-start edge
    // still emits the previous right LSB and the new left MSB follows one SCK later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr     <= '0;
            i2s_sd <= 1'b0;
        end else if (!tx_en) begin
            sr     <= '0;
            i2s_sd <= 1'b0;
        end else if (sck_fall) begin
            i2s_sd <= sr[FW-1];
            if (frame_start)
                sr <= buf_full ? {slot_l, slot_r} : '0;
            else
                sr <= {sr[FW-2:0], 1'b0};
        end
    end

    // One-cycle flag when a frame has to go out as silence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            underrun <= 1'b0;
        else
            underrun <= frame_start && !buf_full;
    end

endmodule
